bvshl_ugt_witness_checker: RTL and testbench
============================================

# bvshl_ugt_witness_checker

Sequential checker for the unsigned-greater-than over left-shift constraint (x << s) >u t. It takes a candidate witness x, a shift amount s and a bound t, and computes the shift and both unsigned comparisons bit-serially. It reports whether the witness satisfies the constraint and whether the invertibility condition holds. It sits downstream of the combinational Skolem-function netlists and cross-checks their outputs on the bench and in hardware self-test.

## Interface
- W, default 4: bit-vector width of x, s and t.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request. High only in IDLE.
- x  in  W  candidate witness.
- s  in  W  shift amount, unsigned.
- t  in  W  bound, unsigned.
- out_valid  out  1  result valid. Held until accepted.
- out_ready  in  1  consumer accepts the result.
- sat  out  1  (x << s) >u t.
- ic  out  1  invertibility condition (~0 << s) >u t.
- mismatch  out  1  sat & ~ic. This pattern is impossible, so a 1 flags an upstream bug.

## Operation
- States: IDLE, SHIFT, CMP, DONE.
- IDLE
  - in_ready=1.
  - When in_valid, capture x into xr, all-ones into mr, t into tr, and load cnt = min(s, W).
  - Go to SHIFT if cnt≠0, otherwise go to CMP with bit index idx=W-1.
- SHIFT
  - Each cycle: xr←xr<<1, mr←mr<<1, and cnt←cnt-1, with zeros filled at the LSB.
  - When cnt reaches 1 in this cycle, go to CMP with idx=W-1.
  - Any s≥W yields xr=mr=0 after W shifts.
- CMP, one bit per cycle, MSB first
  - Two serial comparators run in parallel: xr vs tr, and mr vs tr.
  - Each comparator keeps a decided flag and a gt flag. While undecided, the first bit position where a≠b sets decided=1 and gt=a.
  - After bit 0 is processed, go to DONE.
- DONE
  - out_valid=1.
  - sat = gt of the xr comparator, ic = gt of the mr comparator, mismatch = sat&~ic.
  - On out_ready, go to IDLE.
- Equal operands give gt=0.
- The result registers hold their values until the next DONE.
- Inputs x, s and t are sampled only on the accept cycle. Changes after that are ignored.

## Timing
- Reset: all outputs are registered.
  - in_ready reset value is 1.
  - out_valid, sat, ic and mismatch reset to 0.
  - State resets to IDLE and all internal registers reset to 0.
- Reset takes priority over everything, including mid-SHIFT, mid-CMP and DONE. No result is produced for an aborted request.
- Latency: with the accept at edge T and k=min(s,W), out_valid rises at edge T+1+k+W.
- The earliest next accept is the cycle after the out_valid&out_ready handshake. There is no overlap and no bubble beyond that one cycle.
- Backpressure: while out_valid=1 and out_ready=0, all outputs are stable and in_ready stays 0.
- At most one request is in flight at any time.

## Structure
Shared package bvic_pkg holds:
- the state enum (IDLE, SHIFT, CMP, DONE);
- the default width constant BVIC_W=4;
- a function min_shift(s, W) used for the cnt load.

One sub-module fits naturally: bit_serial_ugt, an MSB-first serial comparator.
- Inputs: clk, rst_n, clear, en, a_bit, b_bit.
- Output: gt.
- It is instantiated twice, once for the witness comparison and once for the mask comparison.

The top level holds the FSM, the shift registers, cnt and idx.

## Test plan
All scenarios use W=4.
- **Basic satisfying case.** Accept x=0011, s=2, t=1010. Shifted value 1100 and mask 1100 both exceed t. Required: sat=1, ic=1, mismatch=0, and out_valid exactly 7 cycles after the accept edge.
- **Oversized shift.** Accept x=1111, s=5, t=0000. k=4, so xr and mr both become 0. Required: sat=0, ic=0, mismatch=0, with latency 9 cycles.
- **Zero shift, equal operands.** Accept s=0, x=0111, t=0111. No SHIFT cycles occur; the equal operands give sat=0, and mask 1111 gives ic=1. Required: latency 5 cycles.
- **Backpressure then back-to-back.** Hold out_ready=0 for 3 cycles after out_valid. Required: sat, ic and mismatch are stable and in_ready=0 throughout. Then raise out_ready with in_valid held high and new operands present. Required: the second request is accepted on the cycle after the handshake and its result is correct.
- **Reset mid-operation.** Deassert rst_n during the second SHIFT cycle of an s=3 request. Required: the next cycle shows in_ready=1 and out_valid=sat=ic=mismatch=0, and no stale result appears afterwards.
- **Randomized cross-check.** Run random x, s, t against a combinational reference model. Required: mismatch never asserts, and sat and ic always match the model.

Source files
------------

// File: rtl/bvshl_ugt_witness_checker_pkg.sv
// Shared types and helpers for the (x << s) >u t witness checker.
// Holds the FSM state encoding, the default width and the shift-count clamp.
package bvic_pkg;

    localparam int BVIC_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CMP   = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Shifting by W or more already clears every bit, so extra shifts are pointless.
    function automatic int min_shift(input int s, input int w);
        return (s < w) ? s : w;
    endfunction

endpackage

// File: rtl/bvshl_ugt_witness_checker_if.sv
// Request/response bundle between a witness producer and the checker.
// The producer drives the request and consumes the verdict; the checker does the reverse.
interface bvshl_ugt_witness_checker_if #(
    parameter int W = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] s;
    logic [W-1:0] t;
    logic         out_valid;
    logic         out_ready;
    logic         sat;
    logic         ic;
    logic         mismatch;

    modport master (
        output in_valid, x, s, t, out_ready,
        input  in_ready, out_valid, sat, ic, mismatch
    );

    modport slave (
        input  in_valid, x, s, t, out_ready,
        output in_ready, out_valid, sat, ic, mismatch
    );
endinterface

// File: rtl/bvshl_ugt_witness_checker_bit_serial_ugt.sv
// MSB-first serial unsigned greater-than comparator.
// The first differing bit position decides the result; equal operands leave gt at 0.
module bit_serial_ugt (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    input  logic a_bit,
    input  logic b_bit,
    output logic gt
);

    logic r_decided;
    logic r_gt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_decided <= 1'b0;
            r_gt      <= 1'b0;
        end else if (clear) begin
            r_decided <= 1'b0;
            r_gt      <= 1'b0;
        end else if (en && !r_decided && (a_bit != b_bit)) begin
            r_decided <= 1'b1;
            r_gt      <= a_bit;
        end
    end

    assign gt = r_gt;

endmodule

// File: rtl/bvshl_ugt_witness_checker.sv
// Bit-serial checker for (x << s) >u t and its invertibility condition (~0 << s) >u t.
// Shifts the witness and an all-ones mask k=min(s,W) times, then compares both against t MSB first.
module bvshl_ugt_witness_checker
    import bvic_pkg::*;
#(
    parameter int W = BVIC_W
) (
    input logic                          clk,
    input logic                          rst_n,
    bvshl_ugt_witness_checker_if.slave   bus
);

    localparam int CNT_W = $clog2(W + 1);
    localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

    state_e             r_state;
    state_e             w_next_state;
    logic [W-1:0]       r_xr;
    logic [W-1:0]       r_mr;
    logic [W-1:0]       r_tr;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_sat;
    logic               r_ic;
    logic               r_mismatch;

    logic               w_accept;
    logic               w_cmp_en;
    logic [CNT_W-1:0]   w_load_cnt;
    logic               w_x_gt;
    logic               w_m_gt;

    assign w_load_cnt = CNT_W'(min_shift(int'(bus.s), W));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_cmp_en     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = (w_load_cnt != '0) ? SHIFT : CMP;
                end
            end
            SHIFT: begin
                if (r_cnt == CNT_W'(1)) w_next_state = CMP;
            end
            CMP: begin
                w_cmp_en = 1'b1;
                if (r_idx == '0) w_next_state = DONE;
            end
            DONE: begin
                if (r_out_valid && bus.out_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_xr        <= '0;
            r_mr        <= '0;
            r_tr        <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_sat       <= 1'b0;
            r_ic        <= 1'b0;
            r_mismatch  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_xr       <= bus.x;
                        r_mr       <= '1;
                        r_tr       <= bus.t;
                        r_cnt      <= w_load_cnt;
                        r_idx      <= IDX_W'(W - 1);
                        r_in_ready <= 1'b0;
                    end
                end
                SHIFT: begin
                    r_xr  <= r_xr << 1;
                    r_mr  <= r_mr << 1;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                CMP: begin
                    if (r_idx != '0) r_idx <= r_idx - IDX_W'(1);
                end
                DONE: begin
                    // First DONE cycle publishes the verdict; comparator flags settled on the last CMP edge.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_sat       <= w_x_gt;
                        r_ic        <= w_m_gt;
                        r_mismatch  <= w_x_gt & ~w_m_gt;
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    bit_serial_ugt u_x_cmp (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_accept),
        .en    (w_cmp_en),
        .a_bit (r_xr[r_idx]),
        .b_bit (r_tr[r_idx]),
        .gt    (w_x_gt)
    );

    bit_serial_ugt u_m_cmp (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_accept),
        .en    (w_cmp_en),
        .a_bit (r_mr[r_idx]),
        .b_bit (r_tr[r_idx]),
        .gt    (w_m_gt)
    );

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sat       = r_sat;
    assign bus.ic        = r_ic;
    assign bus.mismatch  = r_mismatch;

endmodule

// File: tb/tb_bvshl_ugt_witness_checker.sv
// Directed and randomized bench for the (x << s) >u t witness checker at W=4.
// Expected verdicts and latencies are hand-derived or come from a small reference model.
module tb_bvshl_ugt_witness_checker;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    bvshl_ugt_witness_checker_if #(.W(4)) bus ();

    bvshl_ugt_witness_checker #(.W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for in_ready, presents the request across one edge, then scrambles the inputs.
    task automatic send(input string tag, input logic [3:0] x, input logic [3:0] s, input logic [3:0] t);
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.x        = x;
        bus.s        = s;
        bus.t        = t;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.x        = ~x;
        bus.s        = 4'd0;
        bus.t        = ~t;
    endtask

    // Called just after the accept edge; counts edges until out_valid is seen.
    task automatic wait_result(input string tag, input logic es, input logic ei, input int elat);
        int n = 0;
        while (!bus.out_valid && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"},  32'(n),            32'(elat));
        check({tag, "_sat"},      32'(bus.sat),      32'(es));
        check({tag, "_ic"},       32'(bus.ic),       32'(ei));
        check({tag, "_mismatch"}, 32'(bus.mismatch), 32'd0);
    endtask

    task automatic handshake(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_ov_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_rdy_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [3:0] rx, rs, rt, sh_x, sh_m;
        logic       es, ei;
        int         stale;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.x         = '0;
        bus.s         = '0;
        bus.t         = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sat",       32'(bus.sat),       32'd0);
        check("rst_ic",        32'(bus.ic),        32'd0);
        check("rst_mismatch",  32'(bus.mismatch),  32'd0);
        rst_n = 1'b1;

        // 0011<<2 = 1100 > 1010, mask 1100 > 1010; latency 1+2+4.
        send("basic", 4'b0011, 4'd2, 4'b1010);
        wait_result("basic", 1'b1, 1'b1, 7);
        handshake("basic");

        // Reset during the second SHIFT cycle of an s=3 request; sat=1 from above must clear.
        send("abort", 4'b0001, 4'd3, 4'b0000);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_in_ready",  32'(bus.in_ready),  32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_sat",       32'(bus.sat),       32'd0);
        check("abort_ic",        32'(bus.ic),        32'd0);
        check("abort_mismatch",  32'(bus.mismatch),  32'd0);
        rst_n = 1'b1;
        stale = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (bus.out_valid) stale++;
        end
        check("abort_no_stale", 32'(stale), 32'd0);

        // s=5 clamps to 4 shifts, clearing both operands; latency 1+4+4.
        send("oversize", 4'b1111, 4'd5, 4'b0000);
        wait_result("oversize", 1'b0, 1'b0, 9);
        handshake("oversize");

        // No shift; 0111 vs 0111 equal -> sat=0, mask 1111 > 0111 -> ic=1; latency 1+0+4.
        send("zero_shift", 4'b0111, 4'd0, 4'b0111);
        wait_result("zero_shift", 1'b0, 1'b1, 5);
        handshake("zero_shift");

        // 0011<<1 = 0110 > 0101, mask 1110 > 0101; latency 1+1+4. Then stall three cycles.
        send("bp", 4'b0011, 4'd1, 4'b0101);
        wait_result("bp", 1'b1, 1'b1, 6);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid",    32'(bus.out_valid), 32'd1);
            check("bp_hold_sat",      32'(bus.sat),       32'd1);
            check("bp_hold_ic",       32'(bus.ic),        32'd1);
            check("bp_hold_mismatch", 32'(bus.mismatch),  32'd0);
            check("bp_hold_in_ready", 32'(bus.in_ready),  32'd0);
        end
        // Back-to-back: 0001<<3 = 1000 not > 1000, mask 1000 not > 1000; latency 1+3+4.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.x         = 4'b0001;
        bus.s         = 4'd3;
        bus.t         = 4'b1000;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("b2b_ov_drop",  32'(bus.out_valid), 32'd0);
        check("b2b_in_ready", 32'(bus.in_ready),  32'd1);
        @(posedge clk); #1;
        check("b2b_accepted", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        bus.x        = 4'b1111;
        bus.t        = 4'b0000;
        wait_result("b2b", 1'b0, 1'b0, 8);
        handshake("b2b");

        for (int i = 0; i < 24; i++) begin
            rx   = 4'($urandom_range(0, 15));
            rs   = 4'($urandom_range(0, 7));
            rt   = 4'($urandom_range(0, 15));
            sh_x = (rs >= 4'd4) ? 4'b0000 : (rx << rs);
            sh_m = (rs >= 4'd4) ? 4'b0000 : (4'b1111 << rs);
            es   = (sh_x > rt);
            ei   = (sh_m > rt);
            send("rand", rx, rs, rt);
            wait_result("rand", es, ei, 1 + ((rs >= 4'd4) ? 4 : int'(rs)) + 4);
            handshake("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
